// File: rtl/jpeg_coeff_collector.sv
// Collects one 8x8 block of zigzag-ordered coefficients from (run, value) symbols, with per-component DC prediction.
// Optional macro COEFF_SAT_EN: saturate the DC sum instead of wrapping it.
module jpeg_coeff_collector #(
    parameter int WIDTH    = 16,
    parameter int NUM_COMP = 3,
    parameter int COMP_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coef_valid,
    output logic                  coef_ready,
    input  logic [3:0]            coef_run,
    input  logic [WIDTH-1:0]      coef_value,
    input  logic                  coef_eob,
    input  logic [COMP_W-1:0]     coef_comp,
    input  logic                  dc_clear,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [WIDTH*64-1:0]   zz_out_flat,
    output logic [COMP_W-1:0]     blk_comp,
    output logic                  blk_err
);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [6:0]              r_k;
    logic [COMP_W-1:0]       r_blk_comp;
    logic                    r_blk_err;

    logic signed [WIDTH-1:0] w_pred [NUM_COMP];
    logic signed [WIDTH-1:0] w_pred_sel;
    logic signed [WIDTH-1:0] w_dc_sum;
    logic signed [WIDTH-1:0] w_value;
    logic                    w_comp_ok;
    logic                    w_accept;
    logic                    w_at_dc;
    logic                    w_dc_store;
    logic                    w_dc_eob;
    logic                    w_ac_sym;
    logic                    w_ac_eob;
    logic                    w_ac_store;
    logic                    w_ac_ovf;
    logic                    w_handshake;
    logic [7:0]              w_pos;
    logic [7:0]              w_k_adv;

    function automatic logic signed [WIDTH-1:0] dc_sum(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
`ifdef COEFF_SAT_EN
        logic signed [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        // Overflow shows up as the two top bits of the extended sum disagreeing.
        if (s[WIDTH] != s[WIDTH-1])
            dc_sum = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            dc_sum = s[WIDTH-1:0];
`else
        dc_sum = a + b;
`endif
    endfunction

    // Out-of-range components and a same-cycle dc_clear both select a zero predictor.
    always_comb begin
        w_pred_sel = '0;
        w_comp_ok  = 1'b0;
        for (int i = 0; i < NUM_COMP; i++) begin
            if (coef_comp == COMP_W'(i)) begin
                w_comp_ok = 1'b1;
                if (!dc_clear)
                    w_pred_sel = w_pred[i];
            end
        end
    end

    assign w_value     = coef_value;
    assign w_dc_sum    = dc_sum(w_pred_sel, w_value);
    assign w_accept    = coef_valid && (r_state == S_COLLECT);
    assign w_at_dc     = (r_k == 7'd0);
    assign w_dc_store  = w_accept && w_at_dc && !coef_eob;
    assign w_dc_eob    = w_accept && w_at_dc && coef_eob;
    assign w_ac_sym    = w_accept && !w_at_dc && !coef_eob;
    assign w_ac_eob    = w_accept && !w_at_dc && coef_eob;
    assign w_pos       = {1'b0, r_k} + {4'd0, coef_run};
    assign w_k_adv     = w_pos + 8'd1;
    assign w_ac_store  = w_ac_sym && (w_pos <= 8'd63);
    assign w_ac_ovf    = w_ac_sym && (w_pos > 8'd63);
    assign w_handshake = (r_state == S_FULL) && blk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_COLLECT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: begin
                if (w_ac_eob || w_ac_ovf || (w_ac_store && (w_k_adv == 8'd64)))
                    w_state_nxt = S_FULL;
            end
            S_FULL: begin
                if (blk_ready)
                    w_state_nxt = S_COLLECT;
            end
            default: w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= 7'd0;
            r_blk_comp <= '0;
            r_blk_err  <= 1'b0;
        end else if (w_handshake) begin
            r_k       <= 7'd0;
            r_blk_err <= 1'b0;
        end else begin
            if (w_dc_store) begin
                r_k        <= 7'd1;
                r_blk_comp <= coef_comp;
                if (!w_comp_ok)
                    r_blk_err <= 1'b1;
            end
            if (w_ac_store)
                r_k <= w_k_adv[6:0];
            if (w_dc_eob || w_ac_ovf)
                r_blk_err <= 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 64; g++) begin : g_lane
            logic signed [WIDTH-1:0] r_lane;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_lane <= '0;
                else if (w_handshake)
                    r_lane <= '0;
                else if ((g == 0) && w_dc_store)
                    r_lane <= w_dc_sum;
                else if (w_ac_store && (w_pos[5:0] == 6'(g)))
                    r_lane <= w_value;
            end
            assign zz_out_flat[WIDTH*g +: WIDTH] = r_lane;
        end

        for (g = 0; g < NUM_COMP; g++) begin : g_pred
            logic signed [WIDTH-1:0] r_pred;
            // The DC update wins over dc_clear so the cleared-then-applied sum is kept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_pred <= '0;
                else if (w_dc_store && (coef_comp == COMP_W'(g)))
                    r_pred <= w_dc_sum;
                else if (dc_clear)
                    r_pred <= '0;
            end
            assign w_pred[g] = r_pred;
        end
    endgenerate

    assign coef_ready = (r_state == S_COLLECT);
    assign blk_valid  = (r_state == S_FULL);
    assign blk_comp   = r_blk_comp;
    assign blk_err    = r_blk_err;

endmodule

// File: tb/tb_jpeg_coeff_collector.sv
// Directed bench for jpeg_coeff_collector; expected blocks are hand-built zigzag vectors.
module tb_jpeg_coeff_collector;

    localparam int W = 16;

    logic            clk;
    logic            rst_n;
    logic            coef_valid;
    logic            coef_ready;
    logic [3:0]      coef_run;
    logic [W-1:0]    coef_value;
    logic            coef_eob;
    logic [1:0]      coef_comp;
    logic            dc_clear;
    logic            blk_valid;
    logic            blk_ready;
    logic [W*64-1:0] zz_out_flat;
    logic [1:0]      blk_comp;
    logic            blk_err;

    int checks = 0;
    int errors = 0;

    jpeg_coeff_collector #(.WIDTH(W), .NUM_COMP(3), .COMP_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coef_valid  (coef_valid),
        .coef_ready  (coef_ready),
        .coef_run    (coef_run),
        .coef_value  (coef_value),
        .coef_eob    (coef_eob),
        .coef_comp   (coef_comp),
        .dc_clear    (dc_clear),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .zz_out_flat (zz_out_flat),
        .blk_comp    (blk_comp),
        .blk_err     (blk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one symbol and returns #1 after the edge that accepts it.
    task automatic send(input logic [3:0] run, input logic [W-1:0] val,
                        input logic eob, input logic [1:0] comp);
        int n;
        coef_valid = 1'b1;
        coef_run   = run;
        coef_value = val;
        coef_eob   = eob;
        coef_comp  = comp;
        n = 0;
        while (!coef_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: coef_ready=%b required 1", coef_ready);
        end
        @(posedge clk); #1;
        coef_valid = 1'b0;
        coef_eob   = 1'b0;
    endtask

    task automatic handshake();
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        checks++;
        if (blk_valid !== 1'b0 || blk_err !== 1'b0 || blk_comp !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b err=%b comp=%0d required 0 0 0", blk_valid, blk_err, blk_comp);
        end
        checks++;
        if (zz_out_flat !== '0) begin
            errors++;
            $display("FAIL reset_zz: got %h required 0", zz_out_flat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (coef_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: coef_ready=%b required 1", coef_ready);
        end
    endtask

    task automatic test_basic();
        logic [W*64-1:0] exp;
        exp = '0;
        exp[W*0 +: W] = 16'sd5;
        exp[W*1 +: W] = 16'sd3;
        exp[W*4 +: W] = -16'sd1;
        send(4'd0, 16'sd5, 1'b0, 2'd0);
        send(4'd0, 16'sd3, 1'b0, 2'd0);
        send(4'd2, -16'sd1, 1'b0, 2'd0);
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: blk_valid=%b required 0", blk_valid);
        end
        send(4'd0, 16'sd0, 1'b1, 2'd0);
        checks++;
        if (blk_valid !== 1'b1 || blk_err !== 1'b0 || blk_comp !== 2'd0) begin
            errors++;
            $display("FAIL basic_ctrl: valid=%b err=%b comp=%0d required 1 0 0", blk_valid, blk_err, blk_comp);
        end
        checks++;
        if (zz_out_flat !== exp) begin
            errors++;
            $display("FAIL basic_zz: got %h required %h", zz_out_flat, exp);
        end
        handshake();
        checks++;
        if (blk_valid !== 1'b0 || coef_ready !== 1'b1 || zz_out_flat !== '0) begin
            errors++;
            $display("FAIL basic_release: valid=%b ready=%b zz_zero=%b required 0 1 1", blk_valid, coef_ready, zz_out_flat == '0);
        end
    endtask

    task automatic test_pred();
        send(4'd0, -16'sd2, 1'b0, 2'd0);
        send(4'd0, 16'sd0, 1'b1, 2'd0);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd3}) begin
            errors++;
            $display("FAIL pred_comp0: zz0=%0d required 3", $signed(zz_out_flat[W-1:0]));
        end
        handshake();
        send(4'd0, 16'sd7, 1'b0, 2'd1);
        send(4'd0, 16'sd0, 1'b1, 2'd1);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd7} || blk_comp !== 2'd1) begin
            errors++;
            $display("FAIL pred_comp1: zz0=%0d comp=%0d required 7 1", $signed(zz_out_flat[W-1:0]), blk_comp);
        end
        handshake();
    endtask

    task automatic test_full_and_stall();
        logic [W*64-1:0] exp;
        exp = '0;
        exp[W*0 +: W] = 16'sd1;
        send(4'd0, 16'sd1, 1'b0, 2'd2);
        for (int i = 1; i < 64; i++) begin
            exp[W*i +: W] = 16'(i);
            send(4'd0, 16'(i), 1'b0, 2'd2);
        end
        checks++;
        if (blk_valid !== 1'b1 || coef_ready !== 1'b0 || blk_err !== 1'b0 || blk_comp !== 2'd2) begin
            errors++;
            $display("FAIL full_ctrl: valid=%b ready=%b err=%b comp=%0d required 1 0 0 2", blk_valid, coef_ready, blk_err, blk_comp);
        end
        checks++;
        if (zz_out_flat !== exp) begin
            errors++;
            $display("FAIL full_zz: got %h required %h", zz_out_flat, exp);
        end
        coef_valid = 1'b1;
        coef_run   = 4'd0;
        coef_value = 16'sd9;
        coef_eob   = 1'b0;
        coef_comp  = 2'd0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (zz_out_flat !== exp || blk_valid !== 1'b1 || coef_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b ready=%b zz=%h required 1 0 %h", c, blk_valid, coef_ready, zz_out_flat, exp);
            end
        end
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
        checks++;
        if (blk_valid !== 1'b0 || coef_ready !== 1'b1 || zz_out_flat !== '0) begin
            errors++;
            $display("FAIL stall_release: valid=%b ready=%b zz_zero=%b required 0 1 1", blk_valid, coef_ready, zz_out_flat == '0);
        end
        @(posedge clk); #1;
        coef_valid = 1'b0;
        send(4'd0, 16'sd0, 1'b1, 2'd0);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd12} || blk_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_next_dc: zz0=%0d err=%b required 12 0", $signed(zz_out_flat[W-1:0]), blk_err);
        end
        handshake();
    endtask

    task automatic test_overrun();
        logic [W*64-1:0] exp;
        exp = '0;
        exp[W*0 +: W]  = 16'sd12;
        exp[W*59 +: W] = 16'sd2;
        send(4'd0, 16'sd0, 1'b0, 2'd0);
        send(4'd15, 16'sd0, 1'b0, 2'd0);
        send(4'd15, 16'sd0, 1'b0, 2'd0);
        send(4'd15, 16'sd0, 1'b0, 2'd0);
        send(4'd10, 16'sd2, 1'b0, 2'd0);
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early: blk_valid=%b required 0", blk_valid);
        end
        send(4'd5, 16'sd7, 1'b0, 2'd0);
        checks++;
        if (blk_valid !== 1'b1 || blk_err !== 1'b1 || zz_out_flat !== exp) begin
            errors++;
            $display("FAIL overrun_block: valid=%b err=%b zz=%h required 1 1 %h", blk_valid, blk_err, zz_out_flat, exp);
        end
        handshake();
        dc_clear = 1'b1;
        send(4'd0, 16'sd4, 1'b0, 2'd0);
        dc_clear = 1'b0;
        send(4'd0, 16'sd0, 1'b1, 2'd0);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd4} || blk_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_dc: zz0=%0d err=%b required 4 0", $signed(zz_out_flat[W-1:0]), blk_err);
        end
        handshake();
    endtask

    task automatic test_bad_comp();
        send(4'd0, 16'sd5, 1'b0, 2'd3);
        send(4'd0, 16'sd0, 1'b1, 2'd3);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd5} || blk_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_comp: zz0=%0d err=%b required 5 1", $signed(zz_out_flat[W-1:0]), blk_err);
        end
        handshake();
        send(4'd0, 16'sd0, 1'b0, 2'd0);
        send(4'd0, 16'sd0, 1'b1, 2'd0);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd4} || blk_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_comp_pred: zz0=%0d err=%b required 4 0", $signed(zz_out_flat[W-1:0]), blk_err);
        end
        handshake();
    endtask

    task automatic test_eob_at_dc();
        send(4'd0, 16'sd0, 1'b1, 2'd1);
        checks++;
        if (blk_valid !== 1'b0 || coef_ready !== 1'b1) begin
            errors++;
            $display("FAIL eob_dc_state: valid=%b ready=%b required 0 1", blk_valid, coef_ready);
        end
        send(4'd0, 16'sd1, 1'b0, 2'd1);
        send(4'd0, 16'sd0, 1'b1, 2'd1);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd1} || blk_err !== 1'b1 || blk_comp !== 2'd1) begin
            errors++;
            $display("FAIL eob_dc_block: zz0=%0d err=%b comp=%0d required 1 1 1", $signed(zz_out_flat[W-1:0]), blk_err, blk_comp);
        end
        dc_clear = 1'b1;
        @(posedge clk); #1;
        dc_clear = 1'b0;
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd1} || blk_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_in_full: zz0=%0d valid=%b required 1 1", $signed(zz_out_flat[W-1:0]), blk_valid);
        end
        handshake();
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp0;
`ifdef COEFF_SAT_EN
        exp0 = 16'h7FFF;
`else
        exp0 = 16'h8000;
`endif
        dc_clear = 1'b1;
        send(4'd0, 16'sd32767, 1'b0, 2'd1);
        dc_clear = 1'b0;
        send(4'd0, 16'sd0, 1'b1, 2'd1);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd32767}) begin
            errors++;
            $display("FAIL ovf_setup: zz0=%0d required 32767", $signed(zz_out_flat[W-1:0]));
        end
        handshake();
        send(4'd0, 16'sd1, 1'b0, 2'd1);
        send(4'd0, 16'sd0, 1'b1, 2'd1);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, exp0}) begin
            errors++;
            $display("FAIL ovf_dc: zz0=%h required %h", zz_out_flat[W-1:0], exp0);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        send(4'd0, 16'sd5, 1'b0, 2'd2);
        send(4'd1, 16'sd6, 1'b0, 2'd2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (zz_out_flat !== '0 || blk_valid !== 1'b0 || blk_comp !== 2'd0 || coef_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: zz_zero=%b valid=%b comp=%0d ready=%b required 1 0 0 1", zz_out_flat == '0, blk_valid, blk_comp, coef_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(4'd0, 16'sd3, 1'b0, 2'd0);
        send(4'd0, 16'sd0, 1'b1, 2'd0);
        checks++;
        if (zz_out_flat !== {{(W*63){1'b0}}, 16'sd3} || blk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pred: zz0=%0d err=%b required 3 0", $signed(zz_out_flat[W-1:0]), blk_err);
        end
        handshake();
    endtask

    initial begin
        coef_valid = 1'b0;
        coef_run   = 4'd0;
        coef_value = '0;
        coef_eob   = 1'b0;
        coef_comp  = 2'd0;
        dc_clear   = 1'b0;
        blk_ready  = 1'b0;
        test_reset();
        test_basic();
        test_pred();
        test_full_and_stall();
        test_overrun();
        test_bad_comp();
        test_eob_at_dc();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
